// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Default geometry, address/word typedefs and the hardwired-zero index.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback bus of the register file: read ports, write port,
// issue port and scoreboard status. master = core side, slave = regfile.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     we;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     busy_any;

  modport master (
    output rd_addr, we, wr_addr, wr_data,
    output iss_valid, iss_rd,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data,
    input  iss_valid, iss_rd,
    output rd_data, rd_busy, busy_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue,
// cleared on writeback (set wins); per-port busy lookup and busy_any.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic                   clr_en,
  input  logic [AW-1:0]          clr_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  input  logic [NRD-1:0]         fwd_hit,
  output logic [NRD-1:0]         rd_busy,
  output logic                   busy_any
);

  logic [NREGS-1:0] busy;

  // Bit 0 is only ever written by reset, so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (set_en && set_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (clr_en && clr_addr == AW'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  // A forwarded read sees the value being written, so it is only
  // busy when a newer producer of the same register issues now.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      if (fwd_hit[i])
        rd_busy[i] = set_en && (set_addr == clr_addr);
      else
        rd_busy[i] = busy[rd_addr[i]];
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a
// RAW scoreboard. Ports: clk, rst_n, bus (regfile_if.slave).
// Optional REGFILE_BYPASS_EN: same-cycle write-through to read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  logic [XLEN-1:0]          regs [NREGS];
  logic                     wr_hit;
  logic                     set_en;
  logic [NRD-1:0]           fwd;
  logic [NRD-1:0][XLEN-1:0] rd_data_c;

  // Gating with rst_n keeps forwarding from leaking data while the
  // file is held in reset.
  assign wr_hit = rst_n && bus.we
               && (bus.wr_addr != AW'(REG_ZERO));
  assign set_en = rst_n && bus.iss_valid
               && (bus.iss_rd != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr_hit) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      fwd[i] = 1'b0;
`ifdef REGFILE_BYPASS_EN
      fwd[i] = wr_hit && (bus.rd_addr[i] == bus.wr_addr);
`endif
      unique case (1'b1)
        bus.rd_addr[i] == AW'(REG_ZERO):
          rd_data_c[i] = '0;
        fwd[i]:
          rd_data_c[i] = bus.wr_data;
        default:
          rd_data_c[i] = regs[bus.rd_addr[i]];
      endcase
    end
  end

  assign bus.rd_data = rd_data_c;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_addr (bus.iss_rd),
    .clr_en   (wr_hit),
    .clr_addr (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .fwd_hit  (fwd),
    .rd_busy  (bus.rd_busy),
    .busy_any (bus.busy_any)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random
// traffic against an array/bit-map reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(
    .XLEN (XLEN_DEF), .NREGS (NREGS_DEF), .NRD (NRD)
  ) bus ();

  regfile_mp #(
    .XLEN (XLEN_DEF), .NREGS (NREGS_DEF), .NRD (NRD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  xword_t mregs [NREGS_DEF];
  bit     mbusy [NREGS_DEF];

  function automatic bit fwd(int i);
`ifdef REGFILE_BYPASS_EN
    return rst_n && bus.we && bus.wr_addr != 0
        && bus.rd_addr[i] == bus.wr_addr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic xword_t exp_data(int i);
    if (!rst_n || bus.rd_addr[i] == 0) return '0;
    if (fwd(i)) return bus.wr_data;
    return mregs[bus.rd_addr[i]];
  endfunction

  function automatic bit exp_busy(int i);
    if (!rst_n || bus.rd_addr[i] == 0) return 1'b0;
    if (fwd(i))
      return bus.iss_valid && bus.iss_rd == bus.wr_addr;
    return mbusy[bus.rd_addr[i]];
  endfunction

  function automatic bit exp_any();
    for (int r = 0; r < NREGS_DEF; r++)
      if (mbusy[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS_DEF; r++) begin
      mregs[r] = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge: write, clear, then issue
  // (a same-cycle issue overrides the clear).
  task automatic model_commit();
    if (bus.we && bus.wr_addr != 0) begin
      mregs[bus.wr_addr] = bus.wr_data;
      mbusy[bus.wr_addr] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_rd != 0)
      mbusy[bus.iss_rd] = 1'b1;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we        = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd31;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold_any: got %b want 0", bus.busy_any);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NRD; i++) begin
      checks++;
      if (bus.rd_data[i] !== '0) begin
        errors++;
        $display("FAIL rst_data%0d: got %h want 0",
                 i, bus.rd_data[i]);
      end
      checks++;
      if (bus.rd_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy%0d: got %b want 0",
                 i, bus.rd_busy[i]);
      end
    end
    checks++;
    if (bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_any: got %b want 0", bus.busy_any);
    end
  endtask

  task automatic test_write_read();
    bus.we = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    bus.rd_addr[0] = 5'd7;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_x7: got %h want deadbeef", bus.rd_data[0]);
    end
    bus.we = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'h1234_5678;
    tick();
    idle();
    bus.rd_addr[1] = 5'd0;
    #1;
    checks++;
    if (bus.rd_data[1] !== '0) begin
      errors++;
      $display("FAIL wr_x0: got %h want 0", bus.rd_data[1]);
    end
  endtask

  task automatic test_scoreboard();
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd10;
    tick();
    idle();
    bus.rd_addr[0] = 5'd10;
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: got busy=%b any=%b want 1 1",
               bus.rd_busy[0], bus.busy_any);
    end
    bus.we = 1'b1;
    bus.wr_addr = 5'd10;
    bus.wr_data = 32'h0000_00AA;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_clr: got busy=%b any=%b want 0 0",
               bus.rd_busy[0], bus.busy_any);
    end
  endtask

  task automatic test_collision();
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd3;
    tick();
    bus.we = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h0000_0033;
    tick();
    idle();
    bus.rd_addr[1] = 5'd3;
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL coll_set_wins: got %b want 1", bus.rd_busy[1]);
    end
    bus.we = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h0000_0034;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL coll_clear: got busy=%b any=%b want 0 0",
               bus.rd_busy[1], bus.busy_any);
    end
  endtask

  task automatic test_bypass();
    xword_t want;
    bus.rd_addr[1] = 5'd12;
    bus.we = 1'b1;
    bus.wr_addr = 5'd12;
    bus.wr_data = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5_A5A5;
`else
    want = mregs[12];
`endif
    #1;
    checks++;
    if (bus.rd_data[1] !== want) begin
      errors++;
      $display("FAIL byp_same: got %h want %h", bus.rd_data[1], want);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd_data[1] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL byp_next: got %h want a5a5a5a5", bus.rd_data[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus.we        = 1'($urandom_range(0, 1));
      bus.wr_addr   = reg_addr_t'($urandom);
      bus.wr_data   = $urandom;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = ($urandom_range(0, 3) == 0)
                    ? bus.wr_addr : reg_addr_t'($urandom);
      for (int i = 0; i < NRD; i++)
        bus.rd_addr[i] = ($urandom_range(0, 2) == 0)
                       ? bus.wr_addr : reg_addr_t'($urandom);
      #1;
      for (int i = 0; i < NRD; i++) begin
        checks++;
        if (bus.rd_data[i] !== exp_data(i)) begin
          errors++;
          $display("FAIL rnd_data%0d n=%0d: got %h want %h",
                   i, n, bus.rd_data[i], exp_data(i));
        end
        checks++;
        if (bus.rd_busy[i] !== exp_busy(i)) begin
          errors++;
          $display("FAIL rnd_busy%0d n=%0d: got %b want %b",
                   i, n, bus.rd_busy[i], exp_busy(i));
        end
      end
      checks++;
      if (bus.busy_any !== exp_any()) begin
        errors++;
        $display("FAIL rnd_any n=%0d: got %b want %b",
                 n, bus.busy_any, exp_any());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.we = 1'b1;
    bus.wr_addr = 5'd4;
    bus.wr_data = 32'h55;
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd4;
    tick();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd9;
    tick();
    idle();
    bus.rd_addr[0] = 5'd4;
    bus.rd_addr[1] = 5'd9;
    #1;
    checks++;
    if (bus.rd_data[0] !== 32'h55 || bus.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: got %h any=%b want 55 1",
               bus.rd_data[0], bus.busy_any);
    end
    bus.we = 1'b1;
    bus.wr_addr = 5'd4;
    bus.wr_data = 32'hFF;
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd7;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_data[0] !== '0 || bus.busy_any !== 1'b0
        || bus.rd_busy !== '0) begin
      errors++;
      $display("FAIL ar_now: got %h any=%b busy=%b want 0 0 0",
               bus.rd_data[0], bus.busy_any, bus.rd_busy);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    idle();
    bus.rd_addr[1] = 5'd7;
    #1;
    checks++;
    if (bus.rd_data[0] !== '0 || bus.rd_busy[1] !== 1'b0
        || bus.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL ar_drop: got %h b7=%b any=%b want 0 0 0",
               bus.rd_data[0], bus.rd_busy[1], bus.busy_any);
    end
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core; successor to the single-cycle 2-read/1-write file.
- Configurable width, depth and read-port count.
- Register 0 is hardwired to zero.
- Adds a write-pending scoreboard so a pipelined decode stage can detect RAW hazards.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, >= 2).
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD x AW  read addresses, one per port.
- rd_data  out  NRD x XLEN  read data, combinational from rd_addr.
- rd_busy  out  NRD  1 = addressed register has a pending write.
- we  in  1  write enable from writeback.
- wr_addr  in  AW  write destination.
- wr_data  in  XLEN  write data.
- iss_valid  in  1  an instruction with a destination is issuing.
- iss_rd  in  AW  destination of the issuing instruction.
- busy_any  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (rst_n low, asynchronous): all NREGS registers = 0; all scoreboard bits = 0.
  - Consequently rd_data = 0, rd_busy = 0, busy_any = 0 while in reset and on the first cycle after.
  - Reset asserted mid-operation discards any same-cycle write or issue.
- Read: rd_data[i] = reg[rd_addr[i]], zero added latency.
  - rd_addr[i] == 0 always returns 0, and rd_busy[i] = 0.
- Write: on posedge clk with we = 1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - Writes to register 0 are dropped.
- Scoreboard: one busy bit per register, bit 0 is constant 0.
  - Set on posedge when iss_valid = 1 and iss_rd != 0.
  - Cleared on posedge when we = 1 and wr_addr matches, with no same-cycle set.
  - Simultaneous set and clear of the same register: set wins (newer producer pending), bit stays 1.
  - Issue to an already-busy register: bit stays 1; a single writeback clears it. In-order completion is a core-level guarantee.
- rd_busy[i] = busy[rd_addr[i]]; busy_any = |busy.
- Multiple read ports may address the same register; each returns the same value.
- No backpressure. A write to a non-busy register is legal and does not affect the scoreboard.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined (write-through forwarding): if we = 1, wr_addr != 0 and rd_addr[i] == wr_addr, then:
  - rd_data[i] = wr_data in the same cycle.
  - rd_busy[i] = 0, unless iss_valid with iss_rd == wr_addr is also present this cycle, in which case rd_busy[i] = 1.
- Undefined: reads return the pre-write value and rd_busy reflects the registered bit until the edge. Decode must stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF and NREGS_DEF constants.
  - typedef reg_addr_t (logic [AW-1:0] for the default config).
  - typedef xword_t (logic [XLEN-1:0]).
  - localparam REG_ZERO = 0.
- Sub-module regfile_scoreboard (params NREGS, NRD) contains:
  - the busy vector with set/clear priority logic;
  - the per-port rd_busy lookup and busy_any;
  - a bypass-aware clear input.
- Top level keeps the storage array and the read mux/forwarding.

Test Plan:
1. Reset then read: rst_n low 2 cycles, release, rd_addr = {5, 31} -> rd_data = {0, 0}, rd_busy = 0, busy_any = 0.
2. Write/readback: we = 1, wr_addr = 7, wr_data = 0xDEADBEEF; next cycle rd_addr[0] = 7 -> 0xDEADBEEF. Then write 0x12345678 to x0 -> rd_addr = 0 returns 0.
3. Scoreboard: iss_valid = 1, iss_rd = 10 -> next cycle rd_addr = 10 gives rd_busy = 1, busy_any = 1. Then we = 1, wr_addr = 10 -> the cycle after, rd_busy = 0, busy_any = 0.
4. Set/clear collision: reg 3 busy, then in the same cycle we with wr_addr = 3 and iss_valid with iss_rd = 3 -> reg 3 remains busy. A second write to 3 clears it.
5. Bypass: write 0xA5A5A5A5 to x12 while rd_addr[1] = 12 in the same cycle.
   - With REGFILE_BYPASS_EN: rd_data[1] = 0xA5A5A5A5 that cycle.
   - Without: old value that cycle, 0xA5A5A5A5 the next.
6. Async reset mid-op: x4 = 0x55 and busy bits {4, 9} set; pulse rst_n low between clock edges -> rd_data (x4) = 0 and busy_any = 0 immediately, without waiting for a clock edge.
